// File: rtl/ecc_mont_result_collector.sv
// Montgomery result collector: gathers RADIX-bit result words (LSW first) and the top carry,
// then runs a constant-time conditional subtraction of p. ready_o pulses S_NUM+2 cycles after
// the last word is accepted. There is no backpressure: words arriving outside COLLECT are dropped and flagged.
module ecc_mont_result_collector #(
  parameter int RADIX = 32,
  parameter int S_NUM = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     zeroize,
  input  logic                     start_in,
  input  logic [RADIX*S_NUM-1:0]   p_in,
  input  logic                     res_valid_in,
  input  logic [RADIX-1:0]         res_word_in,
  input  logic                     res_carry_in,
  output logic [RADIX*S_NUM-1:0]   result_o,
  output logic                     ready_o,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam int W     = RADIX * S_NUM;
  localparam int CNT_W = (S_NUM > 1) ? $clog2(S_NUM) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(S_NUM - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, SUB, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     t_q, t_d;          // collected (unreduced) result
  logic [W-1:0]     d_q, d_d;          // T - p, built one word per cycle
  logic             borrow_q, borrow_d;
  logic             carry_q, carry_d;  // bit RADIX*S_NUM of the unreduced result
  logic [W-1:0]     result_q, result_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  int               base;              // bit offset of the current word
  logic [RADIX:0]   sub_diff;          // one word of T - p - borrow, top bit is the new borrow

  // Next-state logic: start_in overrides the FSM; subtraction always walks all S_NUM words
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    t_d      = t_q;
    d_d      = d_q;
    borrow_d = borrow_q;
    carry_d  = carry_q;
    result_d = result_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;

    base     = int'(cnt_q) * RADIX;
    sub_diff = {1'b0, t_q[base +: RADIX]} - {1'b0, p_in[base +: RADIX]}
             - {{RADIX{1'b0}}, borrow_q};

    if (start_in) begin
      // A word arriving together with start is intentionally dropped
      state_d  = COLLECT;
      cnt_d    = '0;
      t_d      = '0;
      d_d      = '0;
      borrow_d = 1'b0;
      carry_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (res_valid_in) err_d = 1'b1;
        end
        COLLECT: begin
          if (res_valid_in) begin
            t_d[base +: RADIX] = res_word_in;
            if (cnt_q == LAST) begin
              carry_d  = res_carry_in;
              cnt_d    = '0;
              borrow_d = 1'b0;
              state_d  = SUB;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        SUB: begin
          if (res_valid_in) err_d = 1'b1;
          d_d[base +: RADIX] = sub_diff[RADIX-1:0];
          borrow_d           = sub_diff[RADIX];
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (res_valid_in) err_d = 1'b1;
          // D is the answer whenever T + carry*2^W >= p; input < 2p so one subtraction suffices
          result_d = (carry_q | ~borrow_q) ? d_q : t_q;
          ready_d  = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State registers; zeroize wipes everything exactly like reset
  always_ff @(posedge clk) begin
    if (reset || zeroize) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      t_q      <= '0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      t_q      <= t_d;
      d_q      <= d_d;
      borrow_q <= borrow_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = busy_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_ecc_mont_result_collector.sv
// Bench for ecc_mont_result_collector with RADIX=32, S_NUM=2, p=0x00000005_00000003.
// Vector table drives complete collections; a scoreboard queue holds expected results
// that the ready_o monitor pops. Hand sequences cover abort, zeroize and err_o.
module tb_ecc_mont_result_collector;

  localparam int RADIX = 32;
  localparam int S_NUM = 2;
  localparam int W     = RADIX * S_NUM;

  logic             clk = 1'b0;
  logic             reset;
  logic             zeroize;
  logic             start_in;
  logic [W-1:0]     p_in;
  logic             res_valid_in;
  logic [RADIX-1:0] res_word_in;
  logic             res_carry_in;
  logic [W-1:0]     result_o;
  logic             ready_o;
  logic             busy_o;
  logic             err_o;

  int checks    = 0;
  int errors    = 0;
  int ready_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_result;

  always #5 clk = ~clk;

  ecc_mont_result_collector #(.RADIX(RADIX), .S_NUM(S_NUM)) dut (
    .clk          (clk),
    .reset        (reset),
    .zeroize      (zeroize),
    .start_in     (start_in),
    .p_in         (p_in),
    .res_valid_in (res_valid_in),
    .res_word_in  (res_word_in),
    .res_carry_in (res_carry_in),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every ready pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (ready_o === 1'b1) begin
      ready_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got ready with result 0x%0h, expected no ready", result_o);
      end else begin
        chk("result", result_o, exp_q.pop_front());
      end
    end
  end

  typedef struct {
    string       name;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        carry;
    int          gap;        // idle cycles between the two words
    logic        junk_start; // drive a word together with start (must be dropped)
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[6];

  // Full collection: start, two words, then latency/busy/pulse checks
  task automatic run_op(input string name, input logic [31:0] w0, input logic [31:0] w1,
                        input logic carry, input int gap, input logic junk_start,
                        input logic [W-1:0] exp);
    int lat;
    @(negedge clk);
    start_in = 1'b1;
    if (junk_start) begin
      res_valid_in = 1'b1;
      res_word_in  = 32'h9999_9999;
    end
    @(negedge clk);
    start_in = 1'b0;
    chk({name, "_result_kept_on_start"}, result_o, last_result);
    chk({name, "_busy_collect"}, {63'd0, busy_o}, 64'd1);
    res_valid_in = 1'b1;
    res_word_in  = w0;
    if (gap > 0) begin
      @(negedge clk);
      res_valid_in = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
    @(negedge clk);
    res_valid_in = 1'b1;
    res_word_in  = w1;
    res_carry_in = carry;
    exp_q.push_back(exp);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        res_valid_in = 1'b0;
        res_carry_in = 1'b0;
        chk({name, "_no_err_in_collect"}, {63'd0, err_o}, 64'd0);
      end
      if (i == 2) chk({name, "_busy_sub"}, {63'd0, busy_o}, 64'd1);
      if (ready_o === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk({name, "_latency"}, 64'(lat), 64'd4);
    @(posedge clk);
    #1;
    chk({name, "_ready_one_cycle"}, {63'd0, ready_o}, 64'd0);
    chk({name, "_busy_idle"}, {63'd0, busy_o}, 64'd0);
    last_result = exp;
  endtask

  // Two words with no expected completion (used before an abort)
  task automatic feed_no_result(input logic [31:0] w0, input logic [31:0] w1);
    @(negedge clk);
    start_in = 1'b1;
    @(negedge clk);
    start_in     = 1'b0;
    res_valid_in = 1'b1;
    res_word_in  = w0;
    @(negedge clk);
    res_word_in  = w1;
    @(negedge clk);
    res_valid_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rc;
    vecs[0] = '{"below_p",   32'h0000_0002, 32'h0000_0001, 1'b0, 0, 1'b0, 64'h00000001_00000002};
    vecs[1] = '{"above_p",   32'h0000_0004, 32'h0000_0007, 1'b0, 2, 1'b0, 64'h00000002_00000001};
    vecs[2] = '{"equal_p",   32'h0000_0003, 32'h0000_0005, 1'b0, 0, 1'b0, 64'h0};
    vecs[3] = '{"carry_set", 32'h0000_0001, 32'h0000_0000, 1'b1, 0, 1'b0, 64'hFFFFFFFA_FFFFFFFE};
    vecs[4] = '{"all_ones",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1, 1'b0, 64'hFFFFFFFA_FFFFFFFC};
    vecs[5] = '{"start_drop",32'h0000_0006, 32'h0000_0005, 1'b0, 0, 1'b1, 64'h00000000_00000003};

    reset        = 1'b1;
    zeroize      = 1'b0;
    start_in     = 1'b0;
    p_in         = 64'h00000005_00000003;
    res_valid_in = 1'b0;
    res_word_in  = '0;
    res_carry_in = 1'b0;
    last_result  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_result", result_o, 64'd0);
    chk("reset_ready",  {63'd0, ready_o}, 64'd0);
    chk("reset_busy",   {63'd0, busy_o},  64'd0);
    chk("reset_err",    {63'd0, err_o},   64'd0);

    for (int v = 0; v < 6; v++)
      run_op(vecs[v].name, vecs[v].w0, vecs[v].w1, vecs[v].carry,
             vecs[v].gap, vecs[v].junk_start, vecs[v].exp);

    // Restart during COLLECT: stale 0xAAAAAAAA must not leak into the result
    @(negedge clk);
    start_in = 1'b1;
    @(negedge clk);
    start_in     = 1'b0;
    res_valid_in = 1'b1;
    res_word_in  = 32'hAAAA_AAAA;
    @(negedge clk);
    res_valid_in = 1'b0;
    run_op("restart_collect", 32'h0000_0002, 32'h0000_0001, 1'b0, 0, 1'b0, 64'h00000001_00000002);

    // Restart during SUB: the aborted operation must never raise ready_o
    rc = ready_cnt;
    feed_no_result(32'h0000_0004, 32'h0000_0007);
    run_op("restart_sub", 32'h0000_0003, 32'h0000_0005, 1'b0, 0, 1'b0, 64'h0);
    chk("restart_sub_single_ready", 64'(ready_cnt - rc), 64'd1);

    // Leave a nonzero result, then zeroize in the middle of SUB
    run_op("pre_zeroize", 32'h0000_0004, 32'h0000_0007, 1'b0, 0, 1'b0, 64'h00000002_00000001);
    rc = ready_cnt;
    @(negedge clk);
    start_in = 1'b1;
    @(negedge clk);
    start_in     = 1'b0;
    res_valid_in = 1'b1;
    res_word_in  = 32'h0000_0004;
    @(negedge clk);
    res_word_in  = 32'h0000_0007;
    @(negedge clk);
    res_valid_in = 1'b0;
    zeroize      = 1'b1;
    @(posedge clk);
    #1;
    zeroize = 1'b0;
    chk("zeroize_result", result_o, 64'd0);
    chk("zeroize_busy",   {63'd0, busy_o}, 64'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("zeroize_no_ready", 64'(ready_cnt - rc), 64'd0);

    // Word while IDLE: ignored, err_o pulses for exactly one cycle
    @(negedge clk);
    res_valid_in = 1'b1;
    res_word_in  = 32'h1234_5678;
    @(posedge clk);
    #1;
    res_valid_in = 1'b0;
    chk("idle_err_pulse", {63'd0, err_o}, 64'd1);
    chk("idle_stays_idle", {63'd0, busy_o}, 64'd0);
    @(posedge clk);
    #1;
    chk("idle_err_clears", {63'd0, err_o}, 64'd0);
    chk("idle_result_unchanged", result_o, 64'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
